iterative_divider: RTL
======================

// Module: iterative_divider
// PURPOSE
//  Multi-cycle radix-2 restoring integer divider for the EX-stage muldiv unit; the inverse
//  datapath of the Booth/Wallace multiplier. Serves DIV.W/MOD.W/DIV.WU/MOD.WU: one operation
//  in flight, valid/ready on both sides. Returns quotient and remainder together.
// PARAMETERS
//  WIDTH  32  operand, quotient and remainder width in bits
// PORTS
//  clk           in   1      clock; all state updates on rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  flush_i       in   1      pipeline flush; aborts the current operation
//  req_valid_i   in   1      request valid
//  req_ready_o   out  1      divider can accept a request (high only in IDLE)
//  req_signed_i  in   1      1: two's-complement operands, 0: unsigned
//  dividend_i    in   WIDTH  dividend A
//  divisor_i     in   WIDTH  divisor B
//  res_valid_o   out  1      quotient/remainder valid
//  res_ready_i   in   1      consumer takes result
//  quotient_o    out  WIDTH  A / B, truncated toward zero
//  remainder_o   out  WIDTH  A % B, sign follows dividend
// BEHAVIOUR
//  Reset: state IDLE; req_ready_o=1, res_valid_o=0, quotient_o=0, remainder_o=0.
//  Accept: req_valid_i & req_ready_o & !flush_i; operands and signed flag latched that edge.
//  FSM IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
//   PREP (1 cyc): absolute values when signed; record q_neg = sA^sB, r_neg = sA.
//     If divisor==0: skip to DONE with quotient=all ones, remainder=dividend (raw, unsigned/signed alike).
//   ITER (WIDTH cyc): step counter WIDTH-1..0; per step: partial remainder {r,a_msb} minus |B|,
//     keep if non-negative, quotient bit = 1 else 0; shift in next dividend bit.
//   FIX (1 cyc): negate quotient if q_neg, remainder if r_neg (signed only).
//   DONE: res_valid_o=1, outputs stable until res_ready_i; on res_valid_o & res_ready_i -> IDLE.
//  Latency: accept at edge N -> res_valid_o high in cycle N+WIDTH+3 (normal); N+2 (divide by zero).
//  New request accepted no earlier than the cycle after the result handshake (no overlap).
//  Overflow: signed INT_MIN / -1 -> quotient INT_MIN, remainder 0 (falls out of the datapath).
//  flush_i: highest priority; next edge state=IDLE, res_valid_o=0, counter cleared; a request
//   presented with flush_i is not accepted. Outputs quotient_o/remainder_o hold last value.
//  Async reset mid-operation: immediate return to reset values; no result produced.
//  Counter width $clog2(WIDTH); no wrap beyond 0 -- terminal count forces ITER -> FIX.
//  Internal partial remainder WIDTH+1 bits to hold the subtraction borrow.
// STRUCTURE
//  Package muldiv_pkg: typedef enum logic [2:0] div_state_t {DIV_IDLE,DIV_PREP,DIV_ITER,
//   DIV_FIX,DIV_DONE}; localparam DIV_WIDTH = 32.
//  One sub-module: div_iter_step (combinational): inputs partial remainder, next dividend bit,
//   divisor; outputs new partial remainder and quotient bit. Top holds FSM, counter, registers.
// TESTING
//  unsigned 100 / 7 -> q=14, r=2, res_valid_o exactly WIDTH+3 cycles after accept.
//  signed -7 / 2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); signed 7 / -2 -> q=-3, r=1.
//  signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0; unsigned same -> q=0, r=0x80000000.
//  divisor 0, dividend 0x1234 -> q=0xFFFFFFFF, r=0x1234, valid 2 cycles after accept.
//  flush_i asserted at ITER step 10 -> next cycle IDLE, req_ready_o=1, no res_valid_o; following
//   request 9/3 -> q=3, r=0.
//  hold res_ready_i low 5 cycles in DONE -> outputs stable, req_ready_o=0; async rst_n pulse
//   mid-ITER -> all outputs to reset values immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and sizes for the EX-stage multiply/divide unit.
package muldiv_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_PREP,
    DIV_ITER,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract |B|, keep if non-negative.
// Purely combinational; no latency, no flow control.
module div_iter_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   prem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   prem_o,
  output logic             q_bit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // One extra bit above the shifted remainder so the borrow lands in the MSB.
  assign shifted = {prem_i, dvd_bit_i};
  assign diff    = shifted - {2'b00, divisor_i};
  assign q_bit_o = ~diff[WIDTH+1];
  assign prem_o  = q_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider (DIV/MOD, signed and unsigned): result WIDTH+3 cycles after accept, 2 on divide-by-zero.
// Accepts only in IDLE; the result is held in DONE until res_ready_i, flush_i aborts at any point.
module iterative_divider
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sgn_q, sgn_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   step_prem;
  logic             step_qbit;

  // acc_q shifts the dividend out at the top while quotient bits enter at the bottom.
  div_iter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .prem_i   (prem_q),
    .dvd_bit_i(acc_q[WIDTH-1]),
    .divisor_i(dvs_q),
    .prem_o   (step_prem),
    .q_bit_o  (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (req_valid_i) begin
          acc_d   = dividend_i;
          dvs_d   = divisor_i;
          sgn_d   = req_signed_i;
          state_d = DIV_PREP;
        end
      end
      DIV_PREP: begin
        if (dvs_q == '0) begin
          quot_d  = '1;
          rem_d   = acc_q;
          state_d = DIV_DONE;
        end else begin
          // INT_MIN negates to itself, which is still the correct unsigned magnitude.
          if (sgn_q && acc_q[WIDTH-1]) acc_d = -acc_q;
          if (sgn_q && dvs_q[WIDTH-1]) dvs_d = -dvs_q;
          q_neg_d = sgn_q & (acc_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          r_neg_d = sgn_q & acc_q[WIDTH-1];
          prem_d  = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = DIV_ITER;
        end
      end
      DIV_ITER: begin
        prem_d = step_prem;
        acc_d  = {acc_q[WIDTH-2:0], step_qbit};
        if (cnt_q == '0) begin
          state_d = DIV_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DIV_FIX: begin
        quot_d  = q_neg_q ? -acc_q : acc_q;
        rem_d   = r_neg_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
        state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (res_ready_i) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase

    if (flush_i) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign req_ready_o = (state_q == DIV_IDLE);
  assign res_valid_o = (state_q == DIV_DONE);
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;

endmodule
